// File: rtl/an_encoder_n13_if.sv
// Valid/ready bus for the AN-code encoder: the data word goes in, the
// codeword comes out. The encoder uses the slave view. A producer that
// also consumes the codeword (for example a test harness) uses the master view.
interface an_encoder_n13_if #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned CODE_W = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] codeword;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, codeword, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, codeword, out_data
  );
endinterface

// File: rtl/an_encoder_n13.sv
// AN-code encoder: codeword = A * data.
// The multiply uses shift-add over the bits of A and takes A_W cycles.
// It contains no multiplier.
// Optional feature macro: AN_ENC_SELFCHECK_EN. When it is defined, the
// encoder gains a check_err port. check_err compares acc with data*A while
// the FSM is in DONE.
module an_encoder_n13 #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned A      = 13,
  parameter int unsigned A_W    = 4
) (
  input  logic           clk,
  input  logic           rst,
  an_encoder_n13_if.slave bus,
  output logic           busy
`ifdef AN_ENC_SELFCHECK_EN
  ,
  output logic           check_err
`endif
);

  localparam int unsigned CODE_W = DATA_W + A_W;
  localparam int unsigned IDX_W  = (A_W > 1) ? $clog2(A_W) : 1;
  localparam logic [A_W-1:0]   A_BITS   = A_W'(A);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(A_W - 1);

  // An even A, or an A too wide for A_W, would make the code useless.
  if (((A % 2) == 0) || ((A >> A_W) != 0)) begin : g_bad_a
    $error("an_encoder_n13: A must be odd and below 2**A_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CODE_W-1:0] acc;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] data_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: latch the word on accept. In MUL, add one shifted partial
  // product per cycle. A zero bit of A still consumes its cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      idx    <= '0;
      data_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_r <= bus.in_data;
            acc    <= '0;
            idx    <= '0;
          end
        end
        MUL: begin
          if (A_BITS[idx]) begin
            acc <= acc + (CODE_W'(data_r) << idx);
          end
          idx <= idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and handshake outputs. The codeword is exposed only in
  // DONE, so an aborted word never shows a partial result.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.codeword  = '0;
    bus.out_data  = '0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = MUL;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (idx == IDX_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.codeword  = acc;
        bus.out_data  = data_r;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef AN_ENC_SELFCHECK_EN
  // Independent check of the shift-add result. It is active only while the
  // codeword is on the bus.
  always_comb begin
    check_err = 1'b0;
    if ((state == DONE) && (acc != (CODE_W'(data_r) * CODE_W'(A)))) begin
      check_err = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_an_encoder_n13.sv
// Self-checking bench for an_encoder_n13 (DATA_W=3, A=13, A_W=4).
// The reference is plain arithmetic: codeword = 13*data, latency 4 edges,
// and one word per 6 cycles.
module tb_an_encoder_n13;

  localparam int DATA_W = 3;
  localparam int A_W    = 4;
  localparam int CODE_W = DATA_W + A_W;
  localparam int A      = 13;
  localparam int LAT    = A_W;
  localparam int PERIOD = A_W + 2;

  logic clk;
  logic rst;
  logic busy;
`ifdef AN_ENC_SELFCHECK_EN
  logic check_err;
`endif

  int tests_run = 0;
  int fails     = 0;

  an_encoder_n13_if #(.DATA_W(DATA_W), .CODE_W(CODE_W)) bus ();

  an_encoder_n13 #(.DATA_W(DATA_W), .A(A), .A_W(A_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy)
`ifdef AN_ENC_SELFCHECK_EN
    ,
    .check_err(check_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_code(input int d);
    return d * A;
  endfunction

  // Presents one word, waits for it to be accepted, then waits for
  // out_valid. lat is the number of edges from accept to out_valid,
  // or -1 if the wait timed out.
  task automatic run_word(input logic [DATA_W-1:0] d, output int lat);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = DATA_W'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || int'(bus.codeword) !== 0 ||
        int'(bus.out_data) !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b codeword=%0d out_data=%0d busy=%b, required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.codeword, bus.out_data, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    bus.out_ready = 1'b1;
    run_word(3'd5, lat);
    tests_run++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL basic_latency: got %0d edges, required %0d", lat, LAT);
    end
    tests_run++;
    if (int'(bus.codeword) !== 65 || int'(bus.out_data) !== 5) begin
      fails++;
      $display("FAIL basic_code: codeword=%0d out_data=%0d, required 65 5", bus.codeword, bus.out_data);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_release: out_valid=%b busy=%b, required 0 0", bus.out_valid, busy);
    end
  endtask

  task automatic test_sweep();
    int lat;
    int code;
    for (int d = 0; d < 8; d++) begin
      bus.out_ready = 1'b1;
      run_word(DATA_W'(d), lat);
      code = int'(bus.codeword);
      tests_run++;
      if (lat !== LAT || code !== model_code(d) || int'(bus.out_data) !== d) begin
        fails++;
        $display("FAIL sweep_%0d: lat=%0d codeword=%0d out_data=%0d, required %0d %0d %0d",
                 d, lat, code, bus.out_data, LAT, model_code(d), d);
      end
      tests_run++;
      if ((code % A) !== 0) begin
        fails++;
        $display("FAIL sweep_div_%0d: codeword %0d mod 13 = %0d, required 0", d, code, code % A);
      end
      if (d <= 4) begin
        tests_run++;
        if ((code % 64) % A !== 0) begin
          fails++;
          $display("FAIL sweep_low6_%0d: low 6 bits %0d mod 13 = %0d, required 0",
                   d, code % 64, (code % 64) % A);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    run_word(3'd7, lat);
    tests_run++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL bp_latency: got %0d, required %0d", lat, LAT);
    end
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 3'd2;
      @(posedge clk); #1;
      tests_run++;
      if (int'(bus.codeword) !== 91 || int'(bus.out_data) !== 7 || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold_%0d: codeword=%0d out_data=%0d in_ready=%b out_valid=%b, required 91 7 0 1",
                 c, bus.codeword, bus.out_data, bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_no_accept_on_exit: busy=%b in_ready=%b out_valid=%b, required 0 1 0",
               busy, bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 3'd6;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || int'(bus.codeword) !== 0) begin
      fails++;
      $display("FAIL reset_mul: out_valid=%b busy=%b codeword=%0d, required 0 0 0",
               bus.out_valid, busy, bus.codeword);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_mul_no_output: out_valid seen %0d cycles, required 0", seen);
    end
    run_word(3'd3, lat);
    tests_run++;
    if (lat !== LAT || int'(bus.codeword) !== 39) begin
      fails++;
      $display("FAIL reset_recover: lat=%0d codeword=%0d, required %0d 39", lat, bus.codeword, LAT);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    run_word(3'd4, lat);
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || int'(bus.codeword) !== 0 || int'(bus.out_data) !== 0) begin
      fails++;
      $display("FAIL reset_done: out_valid=%b codeword=%0d out_data=%0d, required 0 0 0",
               bus.out_valid, bus.codeword, bus.out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_random();
    int lat;
    int d;
    int hold;
    for (int n = 0; n < 20; n++) begin
      d    = int'($urandom_range(0, 7));
      hold = int'($urandom_range(0, 3));
      bus.out_ready = 1'b0;
      run_word(DATA_W'(d), lat);
      tests_run++;
      if (lat !== LAT || int'(bus.codeword) !== model_code(d) || int'(bus.out_data) !== d) begin
        fails++;
        $display("FAIL random_%0d: lat=%0d codeword=%0d out_data=%0d, required %0d %0d %0d",
                 n, lat, bus.codeword, bus.out_data, LAT, model_code(d), d);
      end
      for (int h = 0; h < hold; h++) begin
        bus.in_valid = $urandom_range(0, 1) == 1;
        bus.in_data  = DATA_W'($urandom);
        @(posedge clk); #1;
        tests_run++;
        if (bus.out_valid !== 1'b1 || int'(bus.codeword) !== model_code(d)) begin
          fails++;
          $display("FAIL random_hold_%0d: out_valid=%b codeword=%0d, required 1 %0d",
                   n, bus.out_valid, bus.codeword, model_code(d));
        end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL random_release_%0d: out_valid=%b, required 0", n, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int last_rise;
    int got;
    int exp;
    int guard;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = DATA_W'($urandom);
    last_rise = -1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.in_ready && bus.in_valid) q.push_back(int'(bus.in_data));
      @(posedge clk); #1;
      if (bus.out_valid) begin
        got++;
        exp = (q.size() > 0) ? model_code(q[0]) : -1;
        if (q.size() > 0) void'(q.pop_front());
        tests_run++;
        if (int'(bus.codeword) !== exp) begin
          fails++;
          $display("FAIL b2b_code_%0d: codeword=%0d, required %0d", got, bus.codeword, exp);
        end
        if (last_rise >= 0) begin
          tests_run++;
          if (c - last_rise !== PERIOD) begin
            fails++;
            $display("FAIL b2b_period_%0d: %0d cycles, required %0d", got, c - last_rise, PERIOD);
          end
        end
        last_rise = c;
      end
      bus.in_data = DATA_W'($urandom);
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (got < 6) begin
      fails++;
      $display("FAIL b2b_count: %0d words out, required at least 6", got);
    end
    guard = 0;
    while (busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: busy=%b, required 0", busy);
    end
  endtask

`ifdef AN_ENC_SELFCHECK_EN
  task automatic test_selfcheck();
    int lat;
    logic [CODE_W-1:0] bad;
    for (int d = 0; d < 8; d++) begin
      bus.out_ready = 1'b1;
      run_word(DATA_W'(d), lat);
      tests_run++;
      if (check_err !== 1'b0) begin
        fails++;
        $display("FAIL selfcheck_clean_%0d: check_err=%b, required 0", d, check_err);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    run_word(3'd5, lat);
    bad = CODE_W'(65 ^ 1);
    force dut.acc = bad;
    #1;
    tests_run++;
    if (check_err !== 1'b1) begin
      fails++;
      $display("FAIL selfcheck_detect: check_err=%b, required 1", check_err);
    end
    release dut.acc;
    rst = 1'b1;
    #1;
    tests_run++;
    if (check_err !== 1'b0) begin
      fails++;
      $display("FAIL selfcheck_reset: check_err=%b, required 0", check_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef AN_ENC_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
